// File: rtl/reg_bank_shadow.sv
// Double-buffered register bank: byte-strobed writes land in a shadow copy and a
// commit strobe moves every shadow word into the active copy on a single edge.
module reg_bank_shadow #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 4,
   parameter int               NUM_CE    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_CE-1:0]      clk_en,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [WIDTH/8-1:0]     wr_strb,
   input  logic                   commit,
   input  logic                   clear,
   input  logic [AW-1:0]          rd_addr,
   output logic [WIDTH-1:0]       rd_data,
   output logic [DEPTH*WIDTH-1:0] active_out,
   output logic                   pending,
   output logic                   wr_err,
   output logic [15:0]            commit_count
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] shadow     [DEPTH];
   logic [WIDTH-1:0] active     [DEPTH];
   logic [WIDTH-1:0] shadow_nxt [DEPTH];

   logic ce;
   logic wr_in_range;
   logic rd_in_range;
   logic wr_hit;

   assign ce          = &clk_en;
   assign wr_in_range = 32'(wr_addr) < 32'(DEPTH);
   assign rd_in_range = 32'(rd_addr) < 32'(DEPTH);
   assign wr_hit      = wr_en && wr_in_range;

   // Post-write shadow image; feeding it to both copies gives write-into-commit bypass.
   // NOTE: every always_comb output is assigned a full default first so no latch is inferred.
   always_comb begin
      shadow_nxt = shadow;
      if (wr_hit) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) shadow_nxt[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   // NOTE: the register arrays are true flops with async reset, not RAM, so resetting them is legal and required.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            shadow[k] <= RESET_VAL;
            active[k] <= RESET_VAL;
         end
         rd_data      <= RESET_VAL;
         pending      <= 1'b0;
         wr_err       <= 1'b0;
         commit_count <= '0;
      end else if (ce) begin
         rd_data <= rd_in_range ? shadow[rd_addr] : '0;
         if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
               shadow[k] <= RESET_VAL;
               active[k] <= RESET_VAL;
            end
            pending <= 1'b0;
            wr_err  <= 1'b0;
         end else begin
            shadow <= shadow_nxt;
            if (wr_en && !wr_in_range) wr_err <= 1'b1;
            if (commit) begin
               active       <= shadow_nxt;
               pending      <= 1'b0;
               commit_count <= commit_count + 16'd1;
            end else if (wr_hit) begin
               pending <= 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign active_out[k*WIDTH +: WIDTH] = active[k];
   end

endmodule

// File: tb/tb_reg_bank_shadow.sv
// Randomised scoreboard bench for reg_bank_shadow: a driver updates an array-level
// model and queues expected outputs, a monitor pops and compares after each edge.
module tb_reg_bank_shadow;

   localparam int               W     = 32;
   localparam int               DEPTH = 3;
   localparam int               NCE   = 2;
   localparam int               AW    = 2;
   localparam logic [W-1:0]     RV    = 32'hA5A5_0F0F;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [NCE-1:0]       clk_en = '0;
   logic                 wr_en = 1'b0;
   logic [AW-1:0]        wr_addr = '0;
   logic [W-1:0]         wr_data = '0;
   logic [W/8-1:0]       wr_strb = '0;
   logic                 commit = 1'b0;
   logic                 clear = 1'b0;
   logic [AW-1:0]        rd_addr = '0;
   logic [W-1:0]         rd_data;
   logic [DEPTH*W-1:0]   active_out;
   logic                 pending;
   logic                 wr_err;
   logic [15:0]          commit_count;

   reg_bank_shadow #(.WIDTH(W), .DEPTH(DEPTH), .NUM_CE(NCE), .RESET_VAL(RV)) dut (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .commit(commit), .clear(clear),
      .rd_addr(rd_addr), .rd_data(rd_data), .active_out(active_out), .pending(pending),
      .wr_err(wr_err), .commit_count(commit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]       rd;
      logic [DEPTH*W-1:0] act;
      logic               pend;
      logic               err;
      logic [15:0]        cnt;
      bit                 chk;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [W-1:0] m_sh [DEPTH];
   logic [W-1:0] m_ac [DEPTH];
   logic [W-1:0] m_rd;
   logic         m_pend;
   logic         m_err;
   int           m_cnt;

   task automatic check(input string name, input logic [DEPTH*W-1:0] act, input logic [DEPTH*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DEPTH*W-1:0] flat_active();
      logic [DEPTH*W-1:0] f;
      for (int k = 0; k < DEPTH; k++) f[k*W +: W] = m_ac[k];
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         m_sh[k] = RV;
         m_ac[k] = RV;
      end
      m_rd = RV; m_pend = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic check_now(input string tag);
      check({tag, "_rd"},   DEPTH*W'(rd_data),      DEPTH*W'(m_rd));
      check({tag, "_act"},  active_out,             flat_active());
      check({tag, "_pend"}, DEPTH*W'(pending),      DEPTH*W'(m_pend));
      check({tag, "_err"},  DEPTH*W'(wr_err),       DEPTH*W'(m_err));
      check({tag, "_cnt"},  DEPTH*W'(commit_count), DEPTH*W'(16'(m_cnt)));
   endtask

   // One clock of stimulus: drive at negedge, advance the model, queue the expectation.
   task automatic cycle(input logic [NCE-1:0] ce_v, input logic we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [W/8-1:0] ws, input logic cm,
                        input logic cl, input logic [AW-1:0] ra, input bit chk);
      exp_t e;
      @(negedge clk);
      clk_en = ce_v; wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
      commit = cm; clear = cl; rd_addr = ra;
      if (&ce_v) begin
         m_rd = (ra < DEPTH) ? m_sh[ra] : '0;
         if (cl) begin
            for (int k = 0; k < DEPTH; k++) begin
               m_sh[k] = RV;
               m_ac[k] = RV;
            end
            m_pend = 0; m_err = 0;
         end else begin
            if (we && wa < DEPTH) begin
               for (int b = 0; b < W/8; b++)
                  if (ws[b]) m_sh[wa][8*b +: 8] = wd[8*b +: 8];
               m_pend = 1;
            end else if (we) begin
               m_err = 1;
            end
            if (cm) begin
               for (int k = 0; k < DEPTH; k++) m_ac[k] = m_sh[k];
               m_pend = 0;
               m_cnt = (m_cnt + 1) % 65536;
            end
         end
      end
      e.rd = m_rd; e.act = flat_active(); e.pend = m_pend; e.err = m_err;
      e.cnt = 16'(m_cnt); e.chk = chk;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
               check("rd_data",      DEPTH*W'(rd_data),      DEPTH*W'(e.rd));
               check("active_out",   active_out,             e.act);
               check("pending",      DEPTH*W'(pending),      DEPTH*W'(e.pend));
               check("wr_err",       DEPTH*W'(wr_err),       DEPTH*W'(e.err));
               check("commit_count", DEPTH*W'(commit_count), DEPTH*W'(e.cnt));
            end
         end
      end
   end

   initial begin : driver
      int n;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check_now("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Enables not all high: write ignored; then it lands in shadow only
      cycle(2'b10, 1, 2'd1, 32'hDEADBEEF, 4'hF, 0, 0, 2'd1, 1);
      cycle(2'b01, 1, 2'd1, 32'hDEADBEEF, 4'hF, 1, 1, 2'd1, 1);
      cycle(2'b11, 1, 2'd1, 32'hDEADBEEF, 4'hF, 0, 0, 2'd1, 1);
      cycle(2'b11, 0, 2'd0, 32'h0,        4'h0, 0, 0, 2'd1, 1);

      // Byte-lane merge then commit
      cycle(2'b11, 1, 2'd2, 32'h11223344, 4'hF,    0, 0, 2'd2, 1);
      cycle(2'b11, 1, 2'd2, 32'hAABBCCDD, 4'b0101, 0, 0, 2'd2, 1);
      cycle(2'b11, 0, 2'd0, 32'h0,        4'h0,    1, 0, 2'd2, 1);
      cycle(2'b11, 0, 2'd0, 32'h0,        4'h0,    0, 0, 2'd2, 1);

      // Write bypassed into a same-cycle commit; zero-strobe write still sets pending
      cycle(2'b11, 1, 2'd0, 32'h5, 4'hF, 1, 0, 2'd0, 1);
      cycle(2'b11, 1, 2'd1, 32'h7, 4'h0, 0, 0, 2'd0, 1);

      // Out-of-range write/read, sticky error, then clear
      cycle(2'b11, 1, 2'd3, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'd3, 1);
      cycle(2'b11, 0, 2'd0, 32'h0,         4'h0, 0, 0, 2'd3, 1);
      cycle(2'b11, 1, 2'd0, 32'h1234,      4'hF, 0, 0, 2'd0, 1);
      cycle(2'b11, 0, 2'd0, 32'h0,         4'h0, 1, 1, 2'd0, 1);
      cycle(2'b11, 0, 2'd0, 32'h0,         4'h0, 0, 0, 2'd0, 1);

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom % 4 == 0) ? NCE'($urandom) : 2'b11,
               1'($urandom % 2), AW'($urandom), $urandom, (W/8)'($urandom),
               ($urandom % 6 == 0), ($urandom % 30 == 0), AW'($urandom), 1);
      end

      // Commit counter wrap through 0xFFFF to 0x0000
      n = 65536 - m_cnt;
      for (int i = 0; i < n; i++)
         cycle(2'b11, 0, 2'd0, 32'h0, 4'h0, 1, 0, 2'd0, (i % 8192 == 0) || (i >= n - 2));
      cycle(2'b11, 0, 2'd0, 32'h0, 4'h0, 0, 0, 2'd0, 1);

      // Asynchronous reset between edges
      cycle(2'b11, 1, 2'd2, 32'hCAFEF00D, 4'hF, 1, 0, 2'd2, 1);
      cycle(2'b11, 1, 2'd1, 32'h0BADF00D, 4'hF, 0, 0, 2'd2, 1);
      drain();
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_now("async_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
